// File: rtl/matrix_add_pkg.sv
// Shared constants, state type and narrowing helper for the matrix adder slice.
// MATRIX_SUM_SAT_EN selects saturating lane narrowing in sum_lane_narrow.
package matrix_add_pkg;

   localparam int NUM_LANES_C = 12;
   localparam int NUM_SETS_C  = 10;
   localparam int SET_NO_W    = 4;

   typedef enum logic {
      FILL,
      DRAIN
   } state_t;

   function automatic logic signed [63:0] sat_narrow(
      input logic signed [63:0] value,
      input int                 width
   );
      logic signed [63:0] maxV;
      logic signed [63:0] minV;
      maxV = (64'sd1 <<< (width - 1)) - 64'sd1;
      minV = -(64'sd1 <<< (width - 1));
      if (value > maxV)
         return maxV;
      if (value < minV)
         return minV;
      return value;
   endfunction

endpackage

// File: rtl/sum_lane_narrow.sv
// One lane: narrows an (IN_WIDTH+1)-bit sum to IN_WIDTH bits.
// MATRIX_SUM_SAT_EN defined: saturate and flag clipping; else wrap.
module sum_lane_narrow
   import matrix_add_pkg::*;
#(
   parameter int IN_WIDTH = 16
) (
   input  logic signed [IN_WIDTH:0]   sum,
   output logic signed [IN_WIDTH-1:0] narrowed,
   output logic                       clipped
);

`ifdef MATRIX_SUM_SAT_EN
   assign narrowed = IN_WIDTH'(sat_narrow(64'(sum), IN_WIDTH));
   // The extra sum bit disagrees with the sign bit exactly when out of range.
   assign clipped  = sum[IN_WIDTH] ^ sum[IN_WIDTH-1];
`else
   logic unusedMsb;
   assign unusedMsb = sum[IN_WIDTH];
   assign narrowed  = sum[IN_WIDTH-1:0];
   assign clipped   = 1'b0;
`endif

endmodule

// File: rtl/matrix_sum_collector.sv
// Collects 12-lane sum sets into a matrix buffer and streams it row-major.
// MATRIX_SUM_SAT_EN enables saturating narrowing and a live sat_seen flag.
module matrix_sum_collector
   import matrix_add_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int NUM_SETS  = NUM_SETS_C,
   parameter int NUM_LANES = NUM_LANES_C
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic                                 inReady,
   input  logic [SET_NO_W-1:0]                  vectorSetNo,
   input  logic [NUM_LANES*(IN_WIDTH+1)-1:0]    s_vec,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic signed [IN_WIDTH-1:0]           out_data,
   output logic [SET_NO_W-1:0]                  out_row,
   output logic [SET_NO_W-1:0]                  out_col,
   output logic                                 out_last,
   output logic                                 busy_drain,
   output logic                                 seq_err,
   output logic                                 overflow,
   output logic                                 sat_seen
);

   localparam logic [SET_NO_W-1:0] LAST_ROW = SET_NO_W'(NUM_SETS - 1);
   localparam logic [SET_NO_W-1:0] LAST_COL = SET_NO_W'(NUM_LANES - 1);

   state_t state;
   state_t stateNext;

   logic [SET_NO_W-1:0] wrRow;
   logic [SET_NO_W-1:0] rdRow;
   logic [SET_NO_W-1:0] rdCol;
   logic                seqErr;
   logic                ovf;
   logic                satSeen;

   logic signed [IN_WIDTH-1:0] lane [NUM_LANES];
   logic [NUM_LANES-1:0]       clip;
   logic signed [IN_WIDTH-1:0] buffer [NUM_SETS][NUM_LANES];

   logic draining;
   logic capture;
   logic xfer;
   logic lastElem;

   for (genvar k = 0; k < NUM_LANES; k++) begin : gLane
      sum_lane_narrow #(.IN_WIDTH(IN_WIDTH)) uNarrow (
         .sum      (s_vec[k*(IN_WIDTH+1) +: IN_WIDTH+1]),
         .narrowed (lane[k]),
         .clipped  (clip[k])
      );
   end

   assign draining = (state == DRAIN);
   assign capture  = enable && inReady && !draining;
   assign xfer     = enable && draining && out_ready;
   assign lastElem = draining && (rdRow == LAST_ROW) && (rdCol == LAST_COL);

   always_comb begin
      stateNext = state;
      unique case (state)
         FILL:    if (capture && wrRow == LAST_ROW) stateNext = DRAIN;
         DRAIN:   if (xfer && lastElem) stateNext = FILL;
         default: stateNext = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= FILL;
      else if (enable)
         state <= stateNext;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrRow   <= '0;
         rdRow   <= '0;
         rdCol   <= '0;
         seqErr  <= 1'b0;
         ovf     <= 1'b0;
         satSeen <= 1'b0;
      end else if (enable) begin
         if (capture) begin
            wrRow <= (wrRow == LAST_ROW) ? '0 : wrRow + 1'b1;
            if (vectorSetNo != wrRow)
               seqErr <= 1'b1;
            if (|clip)
               satSeen <= 1'b1;
         end
         if (inReady && draining)
            ovf <= 1'b1;
         if (xfer) begin
            if (rdCol == LAST_COL) begin
               rdCol <= '0;
               rdRow <= (rdRow == LAST_ROW) ? '0 : rdRow + 1'b1;
            end else begin
               rdCol <= rdCol + 1'b1;
            end
         end
      end
   end

   // Matrix storage is deliberately left uninitialised by reset.
   always_ff @(posedge clk) begin
      if (!reset && capture)
         for (int k = 0; k < NUM_LANES; k++)
            buffer[wrRow][k] <= lane[k];
   end

   assign out_valid  = draining;
   assign busy_drain = draining;
   assign out_data   = draining ? buffer[rdRow][rdCol] : '0;
   assign out_row    = rdRow;
   assign out_col    = rdCol;
   assign out_last   = lastElem;
   assign seq_err    = seqErr;
   assign overflow   = ovf;
   assign sat_seen   = satSeen;

endmodule

// File: tb/tb_matrix_sum_collector.sv
// Directed bench for matrix_sum_collector (fill, drain, stall, flags, reset).
module tb_matrix_sum_collector;

   localparam int W  = 16;
   localparam int LW = W + 1;
   localparam int NL = 12;
   localparam int NS = 10;

   logic              clk = 0;
   logic              reset = 1;
   logic              enable = 1;
   logic              inReady = 0;
   logic [3:0]        vectorSetNo = 0;
   logic [NL*LW-1:0]  sVec = '0;
   logic              outValid;
   logic              outReady = 0;
   logic signed [W-1:0] outData;
   logic [3:0]        outRow;
   logic [3:0]        outCol;
   logic              outLast;
   logic              busyDrain;
   logic              seqErr;
   logic              overflow;
   logic              satSeen;

   int nCmp = 0;
   int nBad = 0;

   matrix_sum_collector dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .inReady     (inReady),
      .vectorSetNo (vectorSetNo),
      .s_vec       (sVec),
      .out_valid   (outValid),
      .out_ready   (outReady),
      .out_data    (outData),
      .out_row     (outRow),
      .out_col     (outCol),
      .out_last    (outLast),
      .busy_drain  (busyDrain),
      .seq_err     (seqErr),
      .overflow    (overflow),
      .sat_seen    (satSeen)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lanes(input int r, input int off);
      for (int k = 0; k < NL; k++)
         sVec[k*LW +: LW] = LW'(r * 100 + k + off);
   endtask

   task automatic capture(input int setNo);
      vectorSetNo = 4'(setNo);
      inReady = 1;
      step();
      inReady = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      enable = 1;
      inReady = 0;
      outReady = 0;
      step();
      reset = 0;
   endtask

   task automatic drain_count(output int n);
      n = 0;
      outReady = 1;
      for (int i = 0; i < 200 && outValid; i++) begin
         n++;
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1;
      step();
      step();
      nCmp++;
      if ({outValid, busyDrain, outLast, seqErr, overflow, satSeen} !== 6'b0 ||
          outRow !== 0 || outCol !== 0 || outData !== 0) begin
         nBad++;
         $display("FAIL reset_state: got v=%b b=%b l=%b flags=%b%b%b row=%0d col=%0d data=%0d, need all 0",
                  outValid, busyDrain, outLast, seqErr, overflow, satSeen, outRow, outCol, outData);
      end
      reset = 0;
   endtask

   task automatic test_fill_drain();
      int bad;
      do_reset();
      outReady = 1;
      for (int r = 0; r < NS; r++) begin
         set_lanes(r, 0);
         capture(r);
         if (r == NS - 2) begin
            nCmp++;
            if (outValid !== 1'b0) begin
               nBad++;
               $display("FAIL early_valid: got %b need 0", outValid);
            end
         end
      end
      nCmp++;
      if (outValid !== 1'b1 || busyDrain !== 1'b1) begin
         nBad++;
         $display("FAIL valid_latency: got v=%b b=%b need 1 1", outValid, busyDrain);
      end
      bad = 0;
      for (int i = 0; i < NS * NL; i++) begin
         int r = i / NL;
         int k = i % NL;
         nCmp++;
         if (outValid !== 1'b1 || busyDrain !== 1'b1 || outData !== W'(r * 100 + k) ||
             outRow !== 4'(r) || outCol !== 4'(k) || outLast !== (i == NS * NL - 1)) begin
            nBad++;
            if (bad++ < 4)
               $display("FAIL drain_elem %0d: got d=%0d r=%0d c=%0d l=%b v=%b need d=%0d r=%0d c=%0d",
                        i, outData, outRow, outCol, outLast, outValid, r * 100 + k, r, k);
         end
         step();
      end
      nCmp++;
      if (outValid !== 1'b0 || busyDrain !== 1'b0 || seqErr !== 0 || overflow !== 0) begin
         nBad++;
         $display("FAIL drain_end: got v=%b b=%b se=%b ov=%b need 0 0 0 0",
                  outValid, busyDrain, seqErr, overflow);
      end
   endtask

   task automatic test_narrow();
      int n;
      logic signed [W-1:0] e0;
      logic signed [W-1:0] e1;
      logic expSat;
`ifdef MATRIX_SUM_SAT_EN
      e0 = 16'sd32767;
      e1 = -16'sd32768;
      expSat = 1;
`else
      e0 = -16'sd25536;
      e1 = 16'sd15536;
      expSat = 0;
`endif
      do_reset();
      for (int r = 0; r < NS; r++) begin
         set_lanes(r, 0);
         if (r == 0) begin
            sVec[0 +: LW]  = LW'(40000);
            sVec[LW +: LW] = LW'(-50000);
         end
         capture(r);
      end
      nCmp++;
      if (outData !== e0) begin
         nBad++;
         $display("FAIL narrow_lane0: got %0d need %0d", outData, e0);
      end
      outReady = 1;
      step();
      nCmp++;
      if (outData !== e1) begin
         nBad++;
         $display("FAIL narrow_lane1: got %0d need %0d", outData, e1);
      end
      nCmp++;
      if (satSeen !== expSat) begin
         nBad++;
         $display("FAIL sat_seen: got %b need %b", satSeen, expSat);
      end
      drain_count(n);
      nCmp++;
      if (n != NS * NL - 1) begin
         nBad++;
         $display("FAIL narrow_drain_count: got %0d need %0d", n, NS * NL - 1);
      end
   endtask

   task automatic test_stall();
      int n;
      do_reset();
      for (int r = 0; r < NS; r++) begin
         set_lanes(r, 0);
         capture(r);
      end
      outReady = 1;
      step();
      outReady = 0;
      nCmp++;
      if (outCol !== 4'd1 || outData !== 16'sd1) begin
         nBad++;
         $display("FAIL stall_first: got c=%0d d=%0d need 1 1", outCol, outData);
      end
      for (int s = 0; s < 2; s++) begin
         step();
         nCmp++;
         if (outValid !== 1'b1 || outRow !== 0 || outCol !== 4'd1 || outData !== 16'sd1) begin
            nBad++;
            $display("FAIL stall_hold %0d: got v=%b r=%0d c=%0d d=%0d need 1 0 1 1",
                     s, outValid, outRow, outCol, outData);
         end
      end
      outReady = 1;
      step();
      nCmp++;
      if (outCol !== 4'd2 || outData !== 16'sd2) begin
         nBad++;
         $display("FAIL stall_resume: got c=%0d d=%0d need 2 2", outCol, outData);
      end
      drain_count(n);
      nCmp++;
      if (n != NS * NL - 2) begin
         nBad++;
         $display("FAIL stall_remaining: got %0d need %0d", n, NS * NL - 2);
      end
   endtask

   task automatic test_overflow();
      int bad;
      int n;
      do_reset();
      for (int r = 0; r < NS; r++) begin
         set_lanes(r, 0);
         capture(r);
      end
      outReady = 1;
      bad = 0;
      for (int i = 0; i < NS * NL; i++) begin
         int r = i / NL;
         int k = i % NL;
         nCmp++;
         if (outData !== W'(r * 100 + k) || outRow !== 4'(r) || outCol !== 4'(k)) begin
            nBad++;
            if (bad++ < 4)
               $display("FAIL ovf_elem %0d: got d=%0d r=%0d c=%0d need %0d %0d %0d",
                        i, outData, outRow, outCol, r * 100 + k, r, k);
         end
         set_lanes(7, 0);
         vectorSetNo = 0;
         inReady = (i == 5 || i == NS * NL - 1);
         step();
         inReady = 0;
      end
      nCmp++;
      if (overflow !== 1'b1 || outValid !== 1'b0) begin
         nBad++;
         $display("FAIL overflow_flag: got ov=%b v=%b need 1 0", overflow, outValid);
      end
      for (int r = 0; r < NS; r++) begin
         set_lanes(r, 50);
         capture(r);
      end
      nCmp++;
      if (seqErr !== 1'b0 || outData !== 16'sd50 || outValid !== 1'b1) begin
         nBad++;
         $display("FAIL ovf_next_fill: got se=%b d=%0d v=%b need 0 50 1", seqErr, outData, outValid);
      end
      drain_count(n);
      nCmp++;
      if (n != NS * NL) begin
         nBad++;
         $display("FAIL ovf_next_count: got %0d need %0d", n, NS * NL);
      end
   endtask

   task automatic test_seq_err();
      int setNos[NS] = '{0, 1, 2, 5, 4, 5, 6, 7, 8, 9};
      int n;
      do_reset();
      for (int r = 0; r < NS; r++) begin
         set_lanes(r, 0);
         capture(setNos[r]);
         if (r == 2 || r == 3) begin
            nCmp++;
            if (seqErr !== (r == 3)) begin
               nBad++;
               $display("FAIL seq_err_after_%0d: got %b need %b", r + 1, seqErr, r == 3);
            end
         end
      end
      outReady = 1;
      repeat (3 * NL) step();
      nCmp++;
      if (outRow !== 4'd3 || outCol !== 0 || outData !== 16'sd300) begin
         nBad++;
         $display("FAIL seq_row3: got r=%0d c=%0d d=%0d need 3 0 300", outRow, outCol, outData);
      end
      drain_count(n);
   endtask

   task automatic test_reset_mid_drain();
      int bad;
      do_reset();
      for (int r = 0; r < NS; r++) begin
         set_lanes(r, 0);
         capture(0);
      end
      outReady = 1;
      inReady = 1;
      step();
      inReady = 0;
      repeat (59) step();
      nCmp++;
      if (seqErr !== 1'b1 || overflow !== 1'b1 || outRow !== 4'd5) begin
         nBad++;
         $display("FAIL pre_reset: got se=%b ov=%b r=%0d need 1 1 5", seqErr, overflow, outRow);
      end
      reset = 1;
      step();
      reset = 0;
      nCmp++;
      if ({outValid, busyDrain, seqErr, overflow, satSeen} !== 5'b0 ||
          outRow !== 0 || outCol !== 0) begin
         nBad++;
         $display("FAIL mid_reset: got v=%b b=%b se=%b ov=%b ss=%b r=%0d c=%0d need all 0",
                  outValid, busyDrain, seqErr, overflow, satSeen, outRow, outCol);
      end
      for (int r = 0; r < NS; r++) begin
         set_lanes(r, 3);
         capture(r);
      end
      bad = 0;
      for (int i = 0; i < NS * NL; i++) begin
         int r = i / NL;
         int k = i % NL;
         if (i == 30) begin
            enable = 0;
            inReady = 1;
            repeat (5) step();
            nCmp++;
            if (outValid !== 1'b1 || outRow !== 4'd2 || outCol !== 4'd6 || overflow !== 1'b0) begin
               nBad++;
               $display("FAIL enable_hold: got v=%b r=%0d c=%0d ov=%b need 1 2 6 0",
                        outValid, outRow, outCol, overflow);
            end
            enable = 1;
            inReady = 0;
         end
         nCmp++;
         if (outData !== W'(r * 100 + k + 3) || outRow !== 4'(r) || outCol !== 4'(k)) begin
            nBad++;
            if (bad++ < 4)
               $display("FAIL refill_elem %0d: got d=%0d r=%0d c=%0d need %0d %0d %0d",
                        i, outData, outRow, outCol, r * 100 + k + 3, r, k);
         end
         step();
      end
      nCmp++;
      if (outValid !== 1'b0 || seqErr !== 1'b0) begin
         nBad++;
         $display("FAIL refill_end: got v=%b se=%b need 0 0", outValid, seqErr);
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_narrow();
      test_stall();
      test_overflow();
      test_seq_err();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
